// File: rtl/yuv422_word_packer_pkg.sv
// Shared definitions for the 4:2:2 macropixel packer: byte order, field
// offsets and the packed word type.
package yuv422_word_packer_pkg;

  localparam logic [1:0] PH_U  = 2'd0;
  localparam logic [1:0] PH_Y0 = 2'd1;
  localparam logic [1:0] PH_V  = 2'd2;
  localparam logic [1:0] PH_Y1 = 2'd3;

  localparam int U_MSB  = 31;
  localparam int Y0_MSB = 23;
  localparam int V_MSB  = 15;
  localparam int Y1_MSB = 7;

  typedef logic [31:0] macropixel_t;

  function automatic macropixel_t pack_word(input logic [7:0] u, input logic [7:0] y0,
                                            input logic [7:0] v, input logic [7:0] y1);
    macropixel_t w;
    w = 32'd0;
    w[U_MSB  -: 8] = u;
    w[Y0_MSB -: 8] = y0;
    w[V_MSB  -: 8] = v;
    w[Y1_MSB -: 8] = y1;
    return w;
  endfunction

endpackage

// File: rtl/yuv422_word_packer_if.sv
// Byte-in / word-out bundle between the CTE output, the packer and the bus writer.
interface yuv422_word_packer_if
  import yuv422_word_packer_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             yuv_valid;
  logic [7:0]       yuv_in;
  logic             sync_clr;
  logic             word_ready;
  logic             word_valid;
  macropixel_t      word_data;
  logic             almost_full;
  logic             ovf;
  logic [CNT_W-1:0] word_cnt;

  modport slave (
    input  yuv_valid, yuv_in, sync_clr, word_ready,
    output word_valid, word_data, almost_full, ovf, word_cnt
  );

  modport master (
    output yuv_valid, yuv_in, sync_clr, word_ready,
    input  word_valid, word_data, almost_full, ovf, word_cnt
  );
endinterface

// File: rtl/yuv422_word_packer_sync_fifo.sv
// First-word fall-through FIFO with extra-MSB pointers; a push into a full
// FIFO is still accepted when a pop frees a slot on the same edge.
module yuv422_word_packer_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_ready,
  output logic                   o_accept,
  output logic                   o_valid,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_last;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = !w_empty && i_ready;
  assign o_accept = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (o_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_last   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_accept) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // When empty the output keeps showing the last word handed out.
  assign o_valid = !w_empty;
  assign o_data  = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/yuv422_word_packer.sv
// Packs the serial U,Y0,V,Y1 byte stream into 32-bit macropixels, buffers them
// and tracks dropped words and the accepted-word count.
module yuv422_word_packer
  import yuv422_word_packer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  yuv422_word_packer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]    AFULL_P = PW'(AFULL_LVL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_phase;
  logic [7:0]       r_slot0;
  logic [7:0]       r_slot1;
  logic [7:0]       r_slot2;
  logic             r_ovf;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_push;
  logic             w_accept;
  logic             w_valid;
  macropixel_t      w_word;
  macropixel_t      w_data;
  logic [PW-1:0]    w_count;
  logic [PW-1:0]    w_free;

  // A sync_clr byte restarts the word, so it can never complete one.
  assign w_push = bus.yuv_valid && !bus.sync_clr && (r_phase == PH_Y1);
  assign w_word = pack_word(r_slot0, r_slot1, r_slot2, bus.yuv_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= PH_U;
      r_slot0 <= 8'd0;
      r_slot1 <= 8'd0;
      r_slot2 <= 8'd0;
    end else if (bus.sync_clr) begin
      r_phase <= bus.yuv_valid ? PH_Y0 : PH_U;
      if (bus.yuv_valid) r_slot0 <= bus.yuv_in;
    end else if (bus.yuv_valid) begin
      case (r_phase)
        PH_U:    r_slot0 <= bus.yuv_in;
        PH_Y0:   r_slot1 <= bus.yuv_in;
        PH_V:    r_slot2 <= bus.yuv_in;
        default: ;
      endcase
      r_phase <= r_phase + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_push && !w_accept) r_ovf <= 1'b1;
      if (w_accept) r_word_cnt <= r_word_cnt + CNT_ONE;
    end
  end

  yuv422_word_packer_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_push   (w_push),
    .i_data   (w_word),
    .i_ready  (bus.word_ready),
    .o_accept (w_accept),
    .o_valid  (w_valid),
    .o_data   (w_data),
    .o_count  (w_count)
  );

  assign w_free          = DEPTH_P - w_count;
  assign bus.word_valid  = w_valid;
  assign bus.word_data   = w_data;
  assign bus.almost_full = (w_free <= AFULL_P);
  assign bus.ovf         = r_ovf;
  assign bus.word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_yuv422_word_packer.sv
// Scoreboard bench: a byte-list / word-queue reference model predicts every
// word and status flag; a negedge monitor compares against the DUT.
module tb_yuv422_word_packer;
  localparam int DEPTH     = 8;
  localparam int AFULL_LVL = 2;
  localparam int CNT_W     = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  yuv422_word_packer_if #(.CNT_W(CNT_W)) u_if ();

  yuv422_word_packer #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rx_words = 0;

  logic [7:0]       part[$];
  logic [31:0]      sb_q[$];
  int               m_count;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes collect in a list; every fourth forms a word.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      part.delete();
      sb_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_cnt   = '0;
    end else begin
      bit pop, push;
      logic [31:0] w;
      pop  = u_if.word_ready && (m_count > 0);
      push = 1'b0;
      w    = 32'd0;
      if (u_if.sync_clr) part.delete();
      if (u_if.yuv_valid) begin
        part.push_back(u_if.yuv_in);
        if (part.size() == 4) begin
          w = {part[0], part[1], part[2], part[3]};
          part.delete();
          push = 1'b1;
        end
      end
      if (push && (m_count < DEPTH || pop)) begin
        sb_q.push_back(w);
        m_count = m_count + 1;
        m_cnt   = m_cnt + 1'b1;
      end else if (push) begin
        m_ovf = 1'b1;
      end
      if (pop) m_count = m_count - 1;
    end
  end

  // Monitor: status flags every cycle, data on each handshake.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("word_valid", u_if.word_valid, m_count != 0);
      chk("almost_full", u_if.almost_full, (DEPTH - m_count) <= AFULL_LVL);
      chk("ovf", u_if.ovf, m_ovf);
      chk("word_cnt", u_if.word_cnt, m_cnt);
      if (u_if.word_valid && u_if.word_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL word_data: got %0h expected no word at %0t", u_if.word_data, $time);
        end else begin
          chk("word_data", u_if.word_data, sb_q.pop_front());
          rx_words++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic clr, input logic rdy);
    @(posedge clk);
    #1;
    u_if.yuv_valid  = 1'b1;
    u_if.yuv_in     = b;
    u_if.sync_clr   = clr;
    u_if.word_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      u_if.yuv_valid  = 1'b0;
      u_if.sync_clr   = 1'b0;
      u_if.word_ready = rdy;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, u_if.word_valid, 1'b0);
    chk({tag, "_data"}, u_if.word_data, 32'd0);
    chk({tag, "_afull"}, u_if.almost_full, 1'b0);
    chk({tag, "_ovf"}, u_if.ovf, 1'b0);
    chk({tag, "_cnt"}, u_if.word_cnt, 16'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    u_if.yuv_valid  = 1'b0;
    u_if.sync_clr   = 1'b0;
    u_if.word_ready = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int rx0;
    int sent;
    u_if.yuv_valid  = 1'b0;
    u_if.yuv_in     = 8'd0;
    u_if.sync_clr   = 1'b0;
    u_if.word_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_init");
    @(posedge clk);
    #1 reset = 1'b1;

    // Basic word and latency
    send_byte(8'h80, 1'b0, 1'b1);
    send_byte(8'h10, 1'b0, 1'b1);
    send_byte(8'h7F, 1'b0, 1'b1);
    send_byte(8'hEB, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("first_valid", u_if.word_valid, 1'b1);
    chk("first_data", u_if.word_data, 32'h80107FEB);
    chk("first_cnt", u_if.word_cnt, 16'd1);
    idle(3, 1'b1);

    // Fill past full with no consumer
    do_reset();
    for (int w = 0; w < 9; w++) begin
      for (int b = 0; b < 4; b++) send_byte(8'((w << 4) | b), 1'b0, 1'b0);
      idle(1, 1'b0);
      if (w == 4) chk("afull_after5", u_if.almost_full, 1'b0);
      if (w == 5) chk("afull_after6", u_if.almost_full, 1'b1);
    end
    chk("full_cnt", u_if.word_cnt, 16'd8);
    chk("full_ovf", u_if.ovf, 1'b1);

    // Full FIFO: push and pop on the same edge
    send_byte(8'hC1, 1'b0, 1'b0);
    send_byte(8'hC2, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'hC4, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("pushpop_cnt", u_if.word_cnt, 16'd9);
    chk("pushpop_afull", u_if.almost_full, 1'b1);
    idle(12, 1'b1);
    chk("drain_empty", u_if.word_valid, 1'b0);
    chk("drain_sb", sb_q.size(), 0);

    // sync_clr realignment
    rx0 = rx_words;
    send_byte(8'hAA, 1'b0, 1'b1);
    send_byte(8'hBB, 1'b0, 1'b1);
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    send_byte(8'h33, 1'b0, 1'b1);
    send_byte(8'h44, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("clr_data", u_if.word_data, 32'h11223344);
    idle(3, 1'b1);
    chk("clr_words", rx_words - rx0, 1);
    chk("clr_ovf_sticky", u_if.ovf, 1'b1);

    // Reset mid-stream with words and bytes in flight
    for (int b = 0; b < 10; b++) send_byte(8'(8'h50 + b), 1'b0, 1'b0);
    do_reset();
    rx0 = rx_words;
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b1);
    send_byte(8'h04, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("post_rst_data", u_if.word_data, 32'h01020304);
    idle(3, 1'b1);
    chk("post_rst_words", rx_words - rx0, 1);

    // Random 1000-byte stream, random consumer
    rx0  = rx_words;
    sent = 0;
    while (sent < 1000) begin
      if ($urandom_range(3, 0) != 0) begin
        send_byte(8'($urandom), 1'b0, 1'($urandom_range(1, 0)));
        sent++;
      end else begin
        idle(1, 1'($urandom_range(1, 0)));
      end
    end
    idle(40, 1'b1);
    chk("rand_words", rx_words - rx0, 250);
    chk("rand_ovf", u_if.ovf, 1'b0);
    chk("rand_sb", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
